// File: rtl/mem_access_unit_if.sv
// Request/response and data_mem port bundle for mem_access_unit.
// slave is the unit's view; master is the pipeline/memory side.
interface mem_access_unit_if #(
    parameter int WORD_SIZE = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [1:0]           req_size;
    logic                 req_signed;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 resp_valid;
    logic [WORD_SIZE-1:0] resp_rdata;
    logic                 resp_fault;
    logic                 mem_read_en;
    logic                 mem_write_en;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_read_en, mem_write_en, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_read_en, mem_write_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: sub-word loads/stores over a word-only data_mem,
// big-endian lanes, read-modify-write for sub-word stores, fault detection.
module mem_access_unit #(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] MEM_BASE  = 32'd1024
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_unit_if.slave   bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    logic [2:0]           state_r, state_nx_s;
    logic [WORD_SIZE-1:0] addr_r;
    logic [1:0]           size_r;
    logic                 signed_r;
    logic                 fault_r;
    logic [WORD_SIZE-1:0] merge_r;
    logic [WORD_SIZE-1:0] rdata_r;
    logic                 fault_s;
    logic [WORD_SIZE-1:0] load_val_s;
    logic [WORD_SIZE-1:0] merge_val_s;

    // Big-endian lane select: ~off gives the lane's distance from the LSB end.
    function automatic logic [WORD_SIZE-1:0] extract_lane(
        input logic [WORD_SIZE-1:0] word, input logic [1:0] off,
        input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{~off, 3'b000} +: 8];
        h = word[{~off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   extract_lane = sgn ? {{(WORD_SIZE-8){b[7]}}, b}   : {{(WORD_SIZE-8){1'b0}}, b};
            2'b01:   extract_lane = sgn ? {{(WORD_SIZE-16){h[15]}}, h} : {{(WORD_SIZE-16){1'b0}}, h};
            default: extract_lane = word;
        endcase
    endfunction

    function automatic logic [WORD_SIZE-1:0] merge_lane(
        input logic [WORD_SIZE-1:0] word, input logic [WORD_SIZE-1:0] data,
        input logic [1:0] off, input logic [1:0] size);
        logic [WORD_SIZE-1:0] w;
        w = word;
        case (size)
            2'b00:   w[{~off, 3'b000} +: 8]    = data[7:0];
            2'b01:   w[{~off[1], 4'b0000} +: 16] = data[15:0];
            default: w = data;
        endcase
        merge_lane = w;
    endfunction

    // Request fault decode and lane datapaths.
    always_comb begin
        fault_s = (bus.req_size == 2'b11)
               || ((bus.req_size == 2'b01) && bus.req_addr[0])
               || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
               || (bus.req_addr < MEM_BASE);
        load_val_s  = extract_lane(bus.mem_rdata, addr_r[1:0], size_r, signed_r);
        merge_val_s = merge_lane(bus.mem_rdata, merge_r, addr_r[1:0], size_r);
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (!bus.req_valid)            state_nx_s = ST_IDLE;
                else if (fault_s)              state_nx_s = ST_RESP;
                else if (!bus.req_we)          state_nx_s = ST_LOAD;
                else if (bus.req_size == 2'b10) state_nx_s = ST_WRITE;
                else                           state_nx_s = ST_RMW_RD;
            end
            ST_LOAD:   state_nx_s = ST_RESP;
            ST_RMW_RD: state_nx_s = ST_WRITE;
            ST_WRITE:  state_nx_s = ST_RESP;
            ST_RESP:   state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from state so a reset drops memory enables immediately.
    always_comb begin
        bus.req_ready    = (state_r == ST_IDLE);
        bus.resp_valid   = (state_r == ST_RESP);
        bus.resp_fault   = (state_r == ST_RESP) && fault_r;
        bus.resp_rdata   = rdata_r;
        bus.mem_read_en  = (state_r == ST_LOAD) || (state_r == ST_RMW_RD);
        bus.mem_write_en = (state_r == ST_WRITE);
        if (bus.mem_read_en || bus.mem_write_en) begin
            bus.mem_addr = {addr_r[WORD_SIZE-1:2], 2'b00};
        end else begin
            bus.mem_addr = {WORD_SIZE{1'b0}};
        end
        if (bus.mem_write_en) begin
            bus.mem_wdata = merge_r;
        end else begin
            bus.mem_wdata = {WORD_SIZE{1'b0}};
        end
    end

    // State and datapath registers; merge_r carries the store data until RMW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            addr_r   <= {WORD_SIZE{1'b0}};
            size_r   <= 2'b00;
            signed_r <= 1'b0;
            fault_r  <= 1'b0;
            merge_r  <= {WORD_SIZE{1'b0}};
            rdata_r  <= {WORD_SIZE{1'b0}};
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        addr_r   <= bus.req_addr;
                        size_r   <= bus.req_size;
                        signed_r <= bus.req_signed;
                        fault_r  <= fault_s;
                        merge_r  <= bus.req_wdata;
                        if (fault_s) rdata_r <= {WORD_SIZE{1'b0}};
                    end
                end
                ST_LOAD:   rdata_r <= load_val_s;
                ST_RMW_RD: merge_r <= merge_val_s;
                ST_WRITE:  rdata_r <= {WORD_SIZE{1'b0}};
                default:   ;
            endcase
        end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit in the MEM stage, directly upstream of data_mem.
- Accepts byte, halfword and word load/store requests from the EX/MEM pipeline register and drives data_mem's word-only port.
- Performs read-modify-write for sub-word stores, and lane extraction plus sign/zero extension for sub-word loads.
- Flags misaligned and out-of-range accesses instead of issuing them.

Parameters:
- WORD_SIZE, `WORD_SIZE (32): data and address width.
- MEM_BASE, 1024: lowest valid byte address; any request with req_addr < MEM_BASE faults.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend loads (ignored for stores and words).
- req_addr  in  WORD_SIZE  byte address.
- req_wdata  in  WORD_SIZE  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WORD_SIZE  load result, extended.
- resp_fault  out  1  request faulted; valid with resp_valid.
- mem_read_en  out  1  data_mem read enable.
- mem_write_en  out  1  data_mem write enable.
- mem_addr  out  WORD_SIZE  word-aligned address (bits[1:0] = 0).
- mem_wdata  out  WORD_SIZE  full word to write.
- mem_rdata  in  WORD_SIZE  data_mem combinational read data.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - resp_valid = 0, resp_fault = 0, resp_rdata = 0.
  - mem_read_en = 0, mem_write_en = 0, mem_addr = 0, mem_wdata = 0.
- Memory enables are combinational decodes of the state register. Reset mid-operation therefore drops them immediately: no partial write, and the in-flight request is discarded with no response.
- Byte order is big-endian:
  - Byte offset 0 is bits[31:24]; offset 3 is bits[7:0].
  - Halfword offset 0 is [31:16]; offset 2 is [15:0].
- Fault when any of the following holds:
  - req_size = 11.
  - Half with addr[0] = 1.
  - Word with addr[1:0] != 0.
  - req_addr < MEM_BASE.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: req_ready = 1. On req_valid, latch addr, size, signed, we and wdata at the edge, then:
  - Fault → RESP with fault set; no memory access.
  - Load → LOAD.
  - Word store → WRITE, merge register = req_wdata.
  - Sub-word store → RMW_RD.
- LOAD:
  - mem_read_en = 1, mem_addr = {addr[31:2], 2'b00}.
  - At the edge, capture the selected lane into resp_rdata, sign-extended if req_signed else zero-extended; word loads are passed whole.
  - Next state: RESP.
- RMW_RD:
  - mem_read_en = 1.
  - At the edge, merge register = mem_rdata with the target lane(s) replaced by wdata[7:0] (byte) or wdata[15:0] (half).
  - Next state: WRITE.
- WRITE:
  - mem_write_en = 1, mem_wdata = merge register, mem_addr aligned.
  - Next state: RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle; resp_fault reflects the request.
  - resp_rdata = loaded value for loads, 0 for stores and faults.
  - Next state: IDLE.
- Latency, counted from the accept edge E0 to resp_valid high:
  - Fault: cycle after E0.
  - Load and word store: cycle after E1.
  - Sub-word store: cycle after E2.
- No request queue. Requests are accepted only when req_ready = 1; a req_valid held during busy states is ignored until IDLE. Minimum spacing between accepts: fault every 2 cycles, load/word store every 3 cycles, sub-word store every 4 cycles.
- resp_rdata holds its value until the next RESP; resp_fault clears when resp_valid drops.
- mem_addr and mem_wdata are 0 in IDLE and RESP.

Test Plan:
- Word store 0x400 ← 0x11223344, then word load 0x400 → resp_rdata = 0x11223344, resp_fault = 0. resp_valid is high in the 3rd cycle after accept for each access, and mem_write_en is high for exactly 1 cycle.
- Sub-word loads with word 0x400 = 0x8899AABB:
  - LB signed 0x401 → 0xFFFFFF99.
  - LBU 0x403 → 0x000000BB.
  - LH signed 0x402 → 0xFFFFAABB.
  - LHU 0x400 → 0x00008899.
- Sub-word stores, starting from 0x8899AABB:
  - SB 0x402, wdata 0x000000EE → word becomes 0x8899EEBB.
  - Then SH 0x400, wdata 0x00001234 → word becomes 0x1234EEBB.
  - Each store shows 1 read cycle then 1 write cycle, with resp_valid in the 4th cycle after accept.
- Faults:
  - LH 0x401, LW 0x402, size 11 at 0x400, and LW 0x3FC each → resp_valid in the 2nd cycle after accept with resp_fault = 1, resp_rdata = 0.
  - mem_read_en and mem_write_en are never asserted.
- Reset mid-RMW: drive rst_n low during RMW_RD of SB 0x400 → enables drop the same cycle and memory is unchanged. After release: req_ready = 1, resp_valid = 0.
- Back-to-back: hold req_valid with LW 0x400 then LW 0x404 → the second is accepted only in the cycle after RESP, giving exactly 2 responses 3 cycles apart.
